// File: rtl/poly_pack.sv
// poly_pack: assembles a packed GF(2^m) polynomial from a stream of
// coefficients (lowest index first) and zero-fills the slots above the
// requested degree. Coefficient i sits at poly_out[i*COEF_W +: COEF_W],
// so coefficient 0 is leftmost.
//
// Optional build macro: POLY_PACK_LEAD_CHECK_EN
//   When defined, deg_err flags a zero leading coefficient (the one written
//   to slot deg_sat), reported alongside pack_done and held until the next
//   pack_done or reset. When undefined, deg_err is tied low.
module poly_pack #(
   parameter int COEF_W   = 12,
   parameter int NUM_COEF = 12,
   parameter int DAT_W    = 144,
   parameter int DEG_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [DEG_W-1:0]    deg_in,
   input  logic [COEF_W-1:0]   coef_in,
   input  logic                coef_valid,
   output logic                coef_ready,
   output logic                busy,
   output logic                pack_done,
   output logic [0:DAT_W-1]    poly_out,
   output logic                deg_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [DEG_W-1:0] MAX_DEG = DEG_W'(NUM_COEF - 1);

   state_t             state_q, state_d;
   logic [DEG_W-1:0]   idx_q, idx_d;
   logic [DEG_W-1:0]   deg_q, deg_d;
   logic [DEG_W-1:0]   deg_sat;
   logic               accept_start;
   logic               beat;
   logic               last_beat;

   // Work register and published result, one entry per coefficient slot.
   logic [COEF_W-1:0]  work_q [NUM_COEF];
   logic [COEF_W-1:0]  work_d [NUM_COEF];
   logic [COEF_W-1:0]  poly_q [NUM_COEF];

   // Degrees beyond the last slot silently clamp to the top slot.
   assign deg_sat      = (deg_in > MAX_DEG) ? MAX_DEG : deg_in;
   assign accept_start = (state_q == S_IDLE) && start;
   assign beat         = (state_q == S_LOAD) && coef_valid;
   assign last_beat    = beat && (idx_q == deg_q);

   // Per-slot next value: cleared on a new request, written on its beat.
   // Clearing at start is what guarantees zeros above the degree.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_COEF; gi++) begin : g_slot
         assign work_d[gi] = accept_start                          ? '0      :
                             (beat && (idx_q == DEG_W'(gi)))       ? coef_in :
                                                                     work_q[gi];
         assign poly_out[gi*COEF_W +: COEF_W] = poly_q[gi];
      end
   endgenerate

   // State, counters, work register and result register.
   // The result is captured on the final beat so it is already visible
   // during the DONE cycle, together with pack_done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         deg_q   <= '0;
         for (int i = 0; i < NUM_COEF; i++) begin
            work_q[i] <= '0;
            poly_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         deg_q   <= deg_d;
         for (int i = 0; i < NUM_COEF; i++) begin
            work_q[i] <= work_d[i];
            if (last_beat) begin
               poly_q[i] <= work_d[i];
            end
         end
      end
   end

   // Next-state logic and status outputs.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      deg_d      = deg_q;
      coef_ready = 1'b0;
      busy       = 1'b0;
      pack_done  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               deg_d   = deg_sat;
               idx_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            coef_ready = 1'b1;
            busy       = 1'b1;
            if (beat) begin
               if (idx_q == deg_q) begin
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            pack_done = 1'b1;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef POLY_PACK_LEAD_CHECK_EN
   logic deg_err_q;

   // Leading-coefficient check, updated alongside the result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         deg_err_q <= 1'b0;
      end else if (last_beat) begin
         deg_err_q <= (coef_in == '0);
      end
   end

   assign deg_err = deg_err_q;
`else
   assign deg_err = 1'b0;
`endif

endmodule

// File: tb/tb_poly_pack.sv
// Directed testbench for poly_pack. Inputs are driven on the falling edge
// and outputs sampled on the falling edge, away from the active edge.
module tb_poly_pack;

   localparam int COEF_W   = 12;
   localparam int NUM_COEF = 12;
   localparam int DAT_W    = 144;
   localparam int DEG_W    = 4;
`ifdef POLY_PACK_LEAD_CHECK_EN
   localparam bit LEAD = 1'b1;
`else
   localparam bit LEAD = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [DEG_W-1:0]   deg_in;
   logic [COEF_W-1:0]  coef_in;
   logic               coef_valid;
   logic               coef_ready;
   logic               busy;
   logic               pack_done;
   logic [0:DAT_W-1]   poly_out;
   logic               deg_err;

   int checks   = 0;
   int failures = 0;

   logic [COEF_W-1:0]  tb_vals [16];
   logic [0:DAT_W-1]   exp_poly;

   poly_pack #(
      .COEF_W   (COEF_W),
      .NUM_COEF (NUM_COEF),
      .DAT_W    (DAT_W),
      .DEG_W    (DEG_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .deg_in     (deg_in),
      .coef_in    (coef_in),
      .coef_valid (coef_valid),
      .coef_ready (coef_ready),
      .busy       (busy),
      .pack_done  (pack_done),
      .poly_out   (poly_out),
      .deg_err    (deg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DAT_W-1:0] got,
                        input logic [DAT_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference degree detector: index of the highest nonzero slot.
   function automatic int deg_of(input logic [0:DAT_W-1] p);
      int d = 0;
      for (int i = 0; i < NUM_COEF; i++) begin
         if (p[i*COEF_W +: COEF_W] != '0) d = i;
      end
      return d;
   endfunction

   // One full load from tb_vals, called and returning on a falling edge.
   task automatic load(input string tag, input logic [DEG_W-1:0] deg,
                       input bit gaps, input bit start_in_load,
                       input bit start_in_done,
                       input logic [0:DAT_W-1] exp_p, input int exp_lat,
                       input int exp_beats, input bit exp_err);
      int lat;
      int k;
      int it;
      bit ready_ok;
      bit v;
      start  = 1'b1;
      deg_in = deg;
      @(negedge clk);
      start    = 1'b0;
      lat      = 1;
      k        = 0;
      it       = 0;
      ready_ok = 1'b1;
      while (!pack_done && lat < 200) begin
         ready_ok   = ready_ok & coef_ready & busy;
         start      = start_in_load && (it == 1);
         deg_in     = '0;
         v          = !(gaps && (it % 2 == 0)) && (k < 16);
         coef_valid = v;
         coef_in    = tb_vals[k % 16];
         if (v && coef_ready) k++;
         @(negedge clk);
         it++;
         lat++;
      end
      coef_valid = 1'b0;
      start      = 1'b0;
      $display("load %s deg_in=%0d latency=%0d beats=%0d poly_out=%h deg_err=%0b",
               tag, deg, lat, k, poly_out, deg_err);
      check({tag, "_done"},    DAT_W'(pack_done), DAT_W'(1));
      check({tag, "_latency"}, DAT_W'(lat), DAT_W'(exp_lat));
      check({tag, "_beats"},   DAT_W'(k), DAT_W'(exp_beats));
      check({tag, "_ready"},   DAT_W'(ready_ok), DAT_W'(1));
      check({tag, "_poly"},    poly_out, exp_p);
      check({tag, "_deg_err"}, DAT_W'(deg_err), DAT_W'(exp_err));
      check({tag, "_done_rdy"}, DAT_W'(coef_ready), DAT_W'(0));
      start = start_in_done;
      deg_in = 4'd2;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_idle_after"}, DAT_W'(busy), DAT_W'(0));
      check({tag, "_pulse"},      DAT_W'(pack_done), DAT_W'(0));
      check({tag, "_hold"},       poly_out, exp_p);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      deg_in     = '0;
      coef_in    = '0;
      coef_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_poly",  poly_out, '0);
      check("rst_busy",  DAT_W'(busy), DAT_W'(0));
      check("rst_err",   DAT_W'(deg_err), DAT_W'(0));
      rst = 1'b0;

      // Idle with random coef_valid traffic: nothing must happen.
      for (int c = 0; c < 10; c++) begin
         coef_valid = 1'($urandom_range(0, 1));
         coef_in    = 12'($urandom);
         @(negedge clk);
         check("idle_poly",  poly_out, '0);
         check("idle_ready", DAT_W'(coef_ready), DAT_W'(0));
         check("idle_done",  DAT_W'(pack_done), DAT_W'(0));
      end
      coef_valid = 1'b0;

      // Degree 1, back to back.
      tb_vals[0] = 12'h2F7;
      tb_vals[1] = 12'h800;
      for (int i = 2; i < 16; i++) tb_vals[i] = 12'h3A5;
      exp_poly = '0;
      exp_poly[0 +: 12]  = 12'h2F7;
      exp_poly[12 +: 12] = 12'h800;
      load("deg1", 4'd1, 1'b0, 1'b0, 1'b0, exp_poly, 3, 2, 1'b0);
      check("deg1_detect", DAT_W'(deg_of(poly_out)), DAT_W'(1));

      // Degree 11, valid low every other cycle.
      exp_poly = '0;
      for (int i = 0; i < 16; i++) tb_vals[i] = 12'(i + 1);
      for (int i = 0; i < NUM_COEF; i++) exp_poly[i*COEF_W +: COEF_W] = 12'(i + 1);
      load("deg11_gaps", 4'd11, 1'b1, 1'b0, 1'b0, exp_poly, 25, 12, 1'b0);

      // Degree 14 saturates to 11.
      for (int i = 0; i < 16; i++) tb_vals[i] = 12'hFFF;
      exp_poly = '1;
      load("deg14_sat", 4'd14, 1'b0, 1'b0, 1'b0, exp_poly, 13, 12, 1'b0);

      // Start pulses in LOAD and DONE are ignored.
      tb_vals[0] = 12'hABC;
      tb_vals[1] = 12'h123;
      tb_vals[2] = 12'h456;
      exp_poly = '0;
      exp_poly[0 +: 12]  = 12'hABC;
      exp_poly[12 +: 12] = 12'h123;
      exp_poly[24 +: 12] = 12'h456;
      load("start_ign", 4'd2, 1'b0, 1'b1, 1'b1, exp_poly, 4, 3, 1'b0);

      // Reset after 3 of 6 beats of a degree-5 load.
      start  = 1'b1;
      deg_in = 4'd5;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         coef_valid = 1'b1;
         coef_in    = 12'(12'h111 * (i + 1));
         @(negedge clk);
      end
      coef_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      $display("reset mid-load busy=%0b coef_ready=%0b poly_out=%h", busy, coef_ready, poly_out);
      check("midrst_poly",  poly_out, '0);
      check("midrst_busy",  DAT_W'(busy), DAT_W'(0));
      check("midrst_ready", DAT_W'(coef_ready), DAT_W'(0));
      check("midrst_done",  DAT_W'(pack_done), DAT_W'(0));
      check("midrst_err",   DAT_W'(deg_err), DAT_W'(0));
      rst = 1'b0;
      @(negedge clk);

      // Fresh degree-0 load.
      tb_vals[0] = 12'h001;
      exp_poly = '0;
      exp_poly[0 +: 12] = 12'h001;
      load("deg0", 4'd0, 1'b0, 1'b0, 1'b0, exp_poly, 2, 1, 1'b0);

      // Zero leading coefficient, then nonzero leading coefficient.
      tb_vals[0] = 12'h001;
      tb_vals[1] = 12'h002;
      tb_vals[2] = 12'h003;
      tb_vals[3] = 12'h000;
      exp_poly = '0;
      exp_poly[0 +: 12]  = 12'h001;
      exp_poly[12 +: 12] = 12'h002;
      exp_poly[24 +: 12] = 12'h003;
      load("lead_zero", 4'd3, 1'b0, 1'b0, 1'b0, exp_poly, 5, 4, LEAD);
      check("lead_zero_holds", DAT_W'(deg_err), DAT_W'(LEAD));
      tb_vals[3] = 12'h005;
      exp_poly[36 +: 12] = 12'h005;
      load("lead_nz", 4'd3, 1'b0, 1'b0, 1'b0, exp_poly, 5, 4, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/poly_pack.md
Name: poly_pack

Overview:
- Write-side counterpart of the degree-detect block.
- Accepts a target degree plus a stream of GF(2^m) coefficients, lowest index first.
- Assembles the 144-bit packed polynomial in the same layout the degree-detect block consumes, and zero-fills every coefficient slot above the degree.
- Sits between the ALU coefficient datapath and any consumer of packed polynomials, including the degree-detect block.

Parameters:
- COEF_W, 12, coefficient width in bits (GF(2^12)).
- NUM_COEF, 12, number of coefficient slots.
- DAT_W, 144, packed width; must equal COEF_W*NUM_COEF.
- DEG_W, 4, degree field width; must satisfy 2^DEG_W >= NUM_COEF.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request; sampled only in IDLE.
- deg_in  input  DEG_W  target degree; latched with start.
- coef_in  input  COEF_W  coefficient data.
- coef_valid  input  1  coef_in valid this cycle.
- coef_ready  output  1  block accepts a coefficient this cycle.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- pack_done  output  1  one-cycle pulse; poly_out updated in the same cycle.
- poly_out  output  [0:DAT_W-1]  packed result; coefficient i occupies bits [i*COEF_W : i*COEF_W+COEF_W-1], so coefficient 0 is leftmost.
- deg_err  output  1  error flag, valid with pack_done (see Optional Feature).

Behaviour:
- Reset: state=IDLE; coef_ready=0, busy=0, pack_done=0, deg_err=0, poly_out=0; work register, index counter and latched degree all 0.
- States: IDLE, LOAD, DONE.
- IDLE:
  - start=1 latches deg_sat = min(deg_in, NUM_COEF-1), clears the work register to 0, sets idx=0, and goes to LOAD.
  - start=0 holds IDLE.
  - coef_valid is ignored in IDLE.
- LOAD:
  - coef_ready=1.
  - On coef_valid&coef_ready, coef_in is written into slot idx of the work register.
  - If idx==deg_sat the block goes to DONE; otherwise idx increments.
  - coef_valid=0 stalls with no state change and no timeout.
  - start is ignored in LOAD.
- DONE (one cycle):
  - poly_out <= work register; pack_done=1; coef_ready=0.
  - Next state is IDLE.
  - A start asserted during DONE is ignored; a new start is accepted from the following IDLE cycle.
- Latency: with coef_valid held high, pack_done occurs deg_sat+2 cycles after the start cycle (deg_sat+1 LOAD beats plus 1 DONE cycle).
- poly_out only changes in DONE or on reset, so it stays stable while the next polynomial loads.
- Slots above deg_sat are always 0 in the result.
- deg_in above NUM_COEF-1 (12..15) saturates to 11. No flag is raised for saturation.
- Reset asserted mid-LOAD: the partial result is discarded, poly_out is cleared, and the block returns to IDLE on the next edge.

Optional Feature:
- Macro: POLY_PACK_LEAD_CHECK_EN.
- Defined:
  - The block tracks whether the coefficient written to slot deg_sat was zero.
  - In DONE, deg_err=1 if the leading coefficient is zero, meaning the degree-detect block would report a smaller degree.
  - Degree 0 with a zero coefficient also sets deg_err=1.
  - deg_err holds until the next pack_done or reset.
- Undefined: deg_err is tied to 0 and no leading-coefficient tracking logic exists.

Test Plan:
- Reset then idle: poly_out=0, coef_ready=0, pack_done=0 for 10 cycles with random coef_valid toggling.
- start, deg_in=1, coefs 0x2F7, 0x800 back-to-back:
  - pack_done 3 cycles after start.
  - poly_out = 0x2F7800 followed by 120 zero bits; feeding it to the degree-detect block returns 1.
- start, deg_in=11, coefs 1..12 with coef_valid low on every other cycle:
  - coef_ready high throughout LOAD.
  - pack_done after 12 accepted beats; slot i = i+1.
- start, deg_in=14, 12 coefs of 0xFFF: accepts exactly 12 beats, then poly_out is all ones.
- Start pulses issued during LOAD and during DONE are ignored; then rst asserted after 3 of 6 beats of a deg_in=5 load:
  - All outputs return to reset values.
  - A fresh deg_in=0, coef 0x001 load yields slot 0 = 0x001 and the rest zero.
- With POLY_PACK_LEAD_CHECK_EN defined:
  - deg_in=3 with last coef 0x000 gives deg_err=1 with pack_done.
  - A following load with last coef 0x005 gives deg_err=0.
